// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage register: state codes,
// the bubble control value and the saturating counter step.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Replicated to the control width wherever a bubble is inserted.
    localparam logic CTRL_BUBBLE = 1'b0;

    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        sat_inc = (value >= max_val) ? max_val : value + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid flag plus payload register. Clear wins over load,
// and a cleared slot holds an all-zero payload.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_hs.sv
// Parametrised inter-stage register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and saturating stall/flush event counters.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int DW   = 128,
    parameter int CW   = 16,
    parameter int SKID = 1,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [CW-1:0]   in_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [CW-1:0]   out_ctrl,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt,
    output logic [1:0]      o_state
);

    localparam int PW = DW + CW;

    // Handshake: a transfer happens on an edge where valid and ready are both high.
    logic          w_accept;
    logic          w_emit;
    logic          w_main_load;
    logic          w_main_clear;
    logic          w_main_valid;
    logic [PW-1:0] w_main_din;
    logic [PW-1:0] w_main_q;
    logic          w_skid_valid;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = w_main_valid & out_ready;

    pipe_slot #(.W(PW)) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]    r_state;
            logic [1:0]    w_state_next;
            logic          w_skid_load;
            logic          w_skid_clear;
            logic [PW-1:0] w_skid_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_state <= ST_EMPTY;
                else       r_state <= w_state_next;
            end

            always_comb begin
                w_state_next = r_state;
                case (r_state)
                    ST_EMPTY: if (w_accept) w_state_next = ST_ONE;
                    ST_ONE: begin
                        if (w_accept && !w_emit)      w_state_next = ST_FULL;
                        else if (!w_accept && w_emit) w_state_next = ST_EMPTY;
                    end
                    ST_FULL:  if (w_emit) w_state_next = ST_ONE;
                    default:  w_state_next = ST_EMPTY;
                endcase
                if (flush) w_state_next = ST_EMPTY;
            end

            // Ready depends only on the state register, never on out_ready.
            assign in_ready = (r_state != ST_FULL);

            always_comb begin
                w_main_load  = 1'b0;
                w_main_clear = flush;
                w_main_din   = {in_ctrl, in_data};
                w_skid_load  = 1'b0;
                w_skid_clear = flush;
                case (r_state)
                    ST_EMPTY: w_main_load = w_accept;
                    ST_ONE: begin
                        w_main_load = w_accept & w_emit;
                        w_skid_load = w_accept & ~w_emit;
                        if (!w_accept && w_emit) w_main_clear = 1'b1;
                    end
                    ST_FULL: begin
                        if (w_emit) begin
                            w_main_load  = 1'b1;
                            w_main_din   = w_skid_q;
                            w_skid_clear = 1'b1;
                        end
                    end
                    default: w_main_clear = 1'b1;
                endcase
            end

            pipe_slot #(.W(PW)) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_data  ({in_ctrl, in_data}),
                .o_valid (w_skid_valid),
                .o_data  (w_skid_q)
            );

            assign o_state = r_state;
        end else begin : g_single
            assign in_ready     = ~w_main_valid | out_ready;
            assign w_main_load  = w_accept;
            assign w_main_clear = flush | (w_emit & ~w_accept);
            assign w_main_din   = {in_ctrl, in_data};
            assign w_skid_valid = 1'b0;
            assign o_state      = w_main_valid ? ST_ONE : ST_EMPTY;
        end
    endgenerate

    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_main_valid && !out_ready)
                r_stall_cnt <= CNTW'(sat_inc(64'(r_stall_cnt), CNTW));
            if (flush && (w_main_valid || w_skid_valid))
                r_flush_cnt <= CNTW'(sat_inc(64'(r_flush_cnt), CNTW));
        end
    end

    assign out_valid = w_main_valid;
    assign out_data  = w_main_q[DW-1:0];
    assign out_ctrl  = w_main_valid ? w_main_q[PW-1:DW] : {CW{CTRL_BUBBLE}};
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: instance A uses the 2-entry skid buffer, instance B
// the single register with 3-bit counters.
module tb_pipe_stage_hs;

    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int A_MAX = 65535;
    localparam int B_MAX = 7;

    logic clk;
    logic reset;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [15:0]   a_stall_cnt, a_flush_cnt;
    logic [1:0]    a_state;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [2:0]    b_stall_cnt, b_flush_cnt;
    logic [1:0]    b_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: bounded FIFOs of {ctrl, data}, depth 2 (A) and 1 (B).
    logic [DW+CW-1:0] ma_q[$];
    logic [DW+CW-1:0] mb_q[$];
    int ma_stall = 0, ma_flush = 0, mb_stall = 0, mb_flush = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DW(DW), .CW(CW), .SKID(1), .CNTW(16)) u_dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .o_state(a_state)
    );

    pipe_stage_hs #(.DW(DW), .CW(CW), .SKID(0), .CNTW(3)) u_dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .o_state(b_state)
    );

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma_q.delete(); mb_q.delete();
            ma_stall = 0; ma_flush = 0; mb_stall = 0; mb_flush = 0;
        end else begin : model_step
            bit em, ac;
            if (ma_q.size() > 0 && !a_out_ready && ma_stall < A_MAX) ma_stall++;
            if (a_flush) begin
                if (ma_q.size() > 0 && ma_flush < A_MAX) ma_flush++;
                ma_q.delete();
            end else begin
                em = (ma_q.size() > 0) && a_out_ready;
                ac = a_in_valid && (ma_q.size() < 2);
                if (em) void'(ma_q.pop_front());
                if (ac) ma_q.push_back({a_in_ctrl, a_in_data});
            end
            if (mb_q.size() > 0 && !b_out_ready && mb_stall < B_MAX) mb_stall++;
            if (b_flush) begin
                if (mb_q.size() > 0 && mb_flush < B_MAX) mb_flush++;
                mb_q.delete();
            end else begin
                em = (mb_q.size() > 0) && b_out_ready;
                ac = b_in_valid && (mb_q.size() == 0 || b_out_ready);
                if (em) void'(mb_q.pop_front());
                if (ac) mb_q.push_back({b_in_ctrl, b_in_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic ordy, input logic fl);
        a_in_valid = v; a_in_data = d; a_in_ctrl = c; a_out_ready = ordy; a_flush = fl;
    endtask

    task automatic drive_b(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic ordy, input logic fl);
        b_in_valid = v; b_in_data = d; b_in_ctrl = c; b_out_ready = ordy; b_flush = fl;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset a_out_valid got=%0b exp=0", a_out_valid); end
        n_tests++; if (a_out_data !== '0) begin n_fail++; $display("FAIL reset a_out_data got=%0h exp=0", a_out_data); end
        n_tests++; if (a_out_ctrl !== '0) begin n_fail++; $display("FAIL reset a_out_ctrl got=%0h exp=0", a_out_ctrl); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset a_in_ready got=%0b exp=1", a_in_ready); end
        n_tests++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset a_counters got=%0d/%0d exp=0/0", a_stall_cnt, a_flush_cnt); end
        n_tests++; if (b_out_valid !== 1'b0 || b_out_ctrl !== '0) begin n_fail++; $display("FAIL reset b_out got=%0b/%0h exp=0/0", b_out_valid, b_out_ctrl); end
        n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset b_in_ready got=%0b exp=1", b_in_ready); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) begin
            if (i < 8) drive_a(1'b1, DW'(i), CW'($urandom), 1'b1, 1'b0);
            else       drive_a(1'b0, '0, '0, 1'b1, 1'b0);
            @(negedge clk);
            if (i < 8) begin
                n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b in_ready i=%0d got=%0b exp=1", i, a_in_ready); end
            end
            if (i > 0) begin
                n_tests++;
                if (a_out_valid !== 1'b1 || a_out_data !== DW'(i - 1) || a_out_ctrl !== ma_q[0][DW+CW-1:DW]) begin
                    n_fail++; $display("FAIL b2b out i=%0d got=%0b/%0h exp=1/%0h", i, a_out_valid, a_out_data, i - 1);
                end
            end
            tick();
        end
        @(negedge clk);
        n_tests++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0) begin n_fail++; $display("FAIL b2b drained got=%0b/%0h exp=0/0", a_out_valid, a_out_ctrl); end
        n_tests++; if (a_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b stall_cnt got=%0d exp=0", a_stall_cnt); end
        tick();
    endtask

    task automatic test_stall_fill();
        drive_a(1'b1, 32'hA, 16'h00A1, 1'b0, 1'b0); tick();
        drive_a(1'b1, 32'hB, 16'h00B2, 1'b0, 1'b0); tick();
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, 32'hC, 16'h00C3, 1'b0, 1'b0); tick();
        end
        @(negedge clk);
        n_tests++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL fill state got=%0d exp=2", a_state); end
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill in_ready got=%0b exp=0", a_in_ready); end
        n_tests++; if (a_stall_cnt !== 16'd4) begin n_fail++; $display("FAIL fill stall_cnt got=%0d exp=4", a_stall_cnt); end
        n_tests++; if (a_out_data !== 32'hA || a_out_ctrl !== 16'h00A1) begin n_fail++; $display("FAIL fill head_a got=%0h/%0h exp=a/a1", a_out_data, a_out_ctrl); end
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hB) begin n_fail++; $display("FAIL fill head_b got=%0b/%0h exp=1/b", a_out_valid, a_out_data); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill ready_after got=%0b exp=1", a_in_ready); end
        @(negedge clk);
        n_tests++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd4) begin n_fail++; $display("FAIL fill drained got=%0b/%0d exp=0/4", a_out_valid, a_stall_cnt); end
        tick();
    endtask

    task automatic test_flush();
        drive_a(1'b1, 32'h11, 16'h0011, 1'b0, 1'b0); tick();
        drive_a(1'b1, 32'h22, 16'h0022, 1'b0, 1'b0); tick();
        drive_a(1'b1, 32'h33, 16'hFFFF, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (a_state !== 2'd2) begin n_fail++; $display("FAIL flush pre_state got=%0d exp=2", a_state); end
        tick();
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0) begin n_fail++; $display("FAIL flush bubble got=%0b/%0h exp=0/0", a_out_valid, a_out_ctrl); end
        n_tests++; if (a_flush_cnt !== 16'd1) begin n_fail++; $display("FAIL flush flush_cnt got=%0d exp=1", a_flush_cnt); end
        n_tests++; if (a_stall_cnt !== 16'd6) begin n_fail++; $display("FAIL flush stall_cnt got=%0d exp=6", a_stall_cnt); end
        n_tests++; if (a_in_ready !== 1'b1 || a_state !== 2'd0) begin n_fail++; $display("FAIL flush empty got=%0b/%0d exp=1/0", a_in_ready, a_state); end
        for (int k = 0; k < 3; k++) begin
            tick(); @(negedge clk);
            n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush leak k=%0d got=%0b exp=0", k, a_out_valid); end
        end
        tick();
        drive_a(1'b0, '0, '0, 1'b1, 1'b1); tick();
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (a_flush_cnt !== 16'd1) begin n_fail++; $display("FAIL flush empty_flush_cnt got=%0d exp=1", a_flush_cnt); end
        tick();
    endtask

    task automatic test_reset_midstream();
        drive_a(1'b1, 32'h44, 16'h0044, 1'b0, 1'b0); tick();
        drive_a(1'b1, 32'h55, 16'h0055, 1'b0, 1'b0); tick();
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        n_tests++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0) begin n_fail++; $display("FAIL areset out got=%0b/%0h exp=0/0", a_out_valid, a_out_ctrl); end
        n_tests++; if (a_in_ready !== 1'b1 || a_state !== 2'd0) begin n_fail++; $display("FAIL areset ready got=%0b/%0d exp=1/0", a_in_ready, a_state); end
        n_tests++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin n_fail++; $display("FAIL areset counters got=%0d/%0d exp=0/0", a_stall_cnt, a_flush_cnt); end
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_random_a();
        logic pend = 1'b0;
        logic v = 1'b0, ordy, fl;
        logic [DW-1:0] d = '0;
        logic [CW-1:0] c = '0;
        logic [CW-1:0] exp_c;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!pend) begin
                v = ($urandom_range(0, 9) < 7); d = $urandom; c = CW'($urandom);
            end
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 29) == 0);
            drive_a(v, d, c, ordy, fl);
            @(negedge clk);
            exp_c = (ma_q.size() > 0) ? ma_q[0][DW+CW-1:DW] : '0;
            n_tests++; if (a_in_ready !== (ma_q.size() < 2)) begin n_fail++; $display("FAIL rnd in_ready cyc=%0d got=%0b exp=%0b", cyc, a_in_ready, ma_q.size() < 2); end
            n_tests++; if (a_out_valid !== (ma_q.size() > 0) || a_state !== 2'(ma_q.size())) begin n_fail++; $display("FAIL rnd valid cyc=%0d got=%0b/%0d exp=%0d entries", cyc, a_out_valid, a_state, ma_q.size()); end
            n_tests++; if (a_out_ctrl !== exp_c) begin n_fail++; $display("FAIL rnd out_ctrl cyc=%0d got=%0h exp=%0h", cyc, a_out_ctrl, exp_c); end
            if (ma_q.size() > 0) begin
                n_tests++; if (a_out_data !== ma_q[0][DW-1:0]) begin n_fail++; $display("FAIL rnd out_data cyc=%0d got=%0h exp=%0h", cyc, a_out_data, ma_q[0][DW-1:0]); end
            end
            n_tests++; if (a_stall_cnt !== 16'(ma_stall) || a_flush_cnt !== 16'(ma_flush)) begin n_fail++; $display("FAIL rnd counters cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, a_stall_cnt, a_flush_cnt, ma_stall, ma_flush); end
            pend = v && !a_in_ready && !fl;
            tick();
        end
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic test_skid0_toggle();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d = $urandom;
        logic [CW-1:0] c = CW'($urandom);
        logic ordy = 1'b0;
        logic acc;
        int got = 0;
        int cyc = 0;
        while (got < 32 && cyc < 200) begin
            drive_b(1'b1, d, c, ordy, 1'b0);
            @(negedge clk);
            n_tests++; if (b_in_ready !== (mb_q.size() == 0 || ordy)) begin n_fail++; $display("FAIL skid0 in_ready cyc=%0d got=%0b exp=%0b", cyc, b_in_ready, mb_q.size() == 0 || ordy); end
            n_tests++; if (b_out_valid !== (mb_q.size() > 0)) begin n_fail++; $display("FAIL skid0 out_valid cyc=%0d got=%0b exp=%0b", cyc, b_out_valid, mb_q.size() > 0); end
            if (b_out_valid && ordy) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL skid0 extra cyc=%0d got=%0h exp=none", cyc, b_out_data);
                end else if (b_out_data !== exp_q[0]) begin
                    n_fail++; $display("FAIL skid0 order cyc=%0d got=%0h exp=%0h", cyc, b_out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                got++;
            end
            acc = b_in_ready;
            if (acc) exp_q.push_back(d);
            tick();
            if (acc) begin d = $urandom; c = CW'($urandom); end
            ordy = ~ordy;
            cyc++;
        end
        n_tests++; if (got < 32) begin n_fail++; $display("FAIL skid0 timeout got=%0d exp=32 entries", got); end
    endtask

    task automatic test_saturate();
        drive_b(1'b1, 32'h5A5A, 16'h0F0F, 1'b0, 1'b0); tick();
        drive_b(1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_tests++; if (b_stall_cnt !== 3'(mb_stall)) begin n_fail++; $display("FAIL sat step k=%0d got=%0d exp=%0d", k, b_stall_cnt, mb_stall); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (b_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat final got=%0d exp=7", b_stall_cnt); end
        n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL sat held got=%0b exp=1", b_out_valid); end
        tick(); tick();
        @(negedge clk);
        n_tests++; if (b_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat stays got=%0d exp=7", b_stall_cnt); end
        drive_b(1'b0, '0, '0, 1'b1, 1'b0);
        tick(); tick();
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        drive_a(1'b0, '0, '0, 1'b1, 1'b0);
        drive_b(1'b0, '0, '0, 1'b1, 1'b0);
        #1 reset = 1'b1;
        test_reset();
        test_back_to_back();
        test_stall_fill();
        test_flush();
        test_reset_midstream();
        test_random_a();
        test_skid0_toggle();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Parametrised pipeline-stage register, the successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload and a control payload, with valid/ready handshake, stall back-pressure, synchronous flush and an optional 2-entry skid buffer.
- Flush inserts a bubble: control is zeroed so no RegWrite or MemWrite propagates.
- Exposes stall and flush event counters for the debug unit.

Parameters:
DW, 128, data payload width (pc, operands, immediates, register indices packed by the instantiating stage)
CW, 16, control payload width (WB/M/EX control bits, opcode)
SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
CNTW, 16, width of the saturating event counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous flush: discard all held entries and the current input
in_valid  in  1  upstream stage presents an entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DW  data payload
in_ctrl  in  CW  control payload
out_valid  out  1  entry available downstream
out_ready  in  1  downstream accepts; low = stall
out_data  out  DW  data of the head entry
out_ctrl  out  CW  control of the head entry; all zero when out_valid=0
stall_cnt  out  CNTW  cycles with out_valid & !out_ready, saturating
flush_cnt  out  CNTW  flush cycles that discarded at least one valid entry, saturating

Behaviour:
- Reset (async, any time, including mid-transfer): both slots invalid, all payload registers 0, counters 0. Outputs after reset: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
- Handshake:
  - Accept = in_valid & in_ready. Emit = out_valid & out_ready.
  - Latency is 1 cycle: an entry accepted at edge N is visible at out_* after edge N.
  - Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- SKID=1, state machine {EMPTY, ONE, FULL}:
  - out_* always driven from the main slot; skid slot holds the overflow entry.
  - in_ready = (state != FULL), registered; no combinational in-to-out ready path.
  - EMPTY: accept -> ONE (main <= input).
  - ONE:
    - accept & emit -> ONE (main <= input).
    - accept & !emit -> FULL (skid <= input).
    - !accept & emit -> EMPTY.
    - otherwise hold.
  - FULL: emit -> ONE (main <= skid). No accept possible.
  - Sustained throughput is 1 entry/cycle with out_ready held high.
- SKID=0:
  - Single main slot; in_ready = !out_valid | out_ready (combinational).
  - Accept loads main; emit without accept -> empty.
- Flush (priority over everything except reset):
  - Next state EMPTY; both valid bits cleared; ctrl registers <= 0; data registers <= 0.
  - An input presented in the flush cycle is discarded even if in_ready=1.
  - Emit in the flush cycle still counts as completed downstream; this is the downstream's responsibility.
  - flush_cnt increments if any slot was valid before the edge.
- Bubble rule: out_ctrl is forced to 0 whenever out_valid=0, so a downstream stage that ignores valid still sees no side-effect controls.
- Counters:
  - Increment by 1 per qualifying cycle and saturate at 2^CNTW-1 (no wrap).
  - Cleared only by reset. Flush does not clear them.
  - stall_cnt counts in the flush cycle if its condition holds.
- Stall with in_valid held and in_ready low: upstream must hold its payload stable. The stage does not sample it.

Decomposition:
- Shared package pipe_pkg:
  - State encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - A function for the saturating increment.
  - A CTRL_BUBBLE constant (all zero).
- Natural sub-module pipe_slot: one valid bit plus DW+CW payload register with load/clear and async reset.
  - Instantiated once for main; once more for skid when SKID=1 (generate).
- Counters are inline in the top.

Test Plan:
1. Reset asserted mid-stream with state FULL -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0, flush_cnt=0 immediately (async), with no edge required.
2. SKID=1, out_ready=1, 8 back-to-back entries data=0..7 -> out_data 0..7 on consecutive cycles starting 1 cycle after first accept; in_ready stays 1.
3. SKID=1: accept A, B, then deassert out_ready for 4 cycles -> state FULL, in_ready=0, stall_cnt=4. Release -> A then B emitted in order, in_ready=1 the cycle after A emits.
4. FULL state, flush=1 with in_valid=1, in_ctrl=16'hFFFF -> next cycle out_valid=0, out_ctrl=0, input not delivered, flush_cnt=1. A flush while EMPTY leaves flush_cnt unchanged.
5. SKID=0, out_ready toggling every cycle, continuous in_valid -> in_ready equals !out_valid|out_ready each cycle; no loss or duplication over 32 entries; scoreboard matches.
6. CNTW=3, out_ready=0 for 10 cycles with an entry held -> stall_cnt reaches 7 and stays 7.
